// File: rtl/kacc_fp16_normalizer_pkg.sv
// Shared definitions for the Kulisch-accumulator -> binary16 normalizer.
// Holds the normalizer FSM state type, the accumulator geometry defaults,
// and the binary16 bias, max-finite and infinity constants.
package kacc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } kacc_state_t;

  localparam int unsigned KACC_AWIDTH     = 91;
  localparam int unsigned KACC_FRAC_BITS  = 48;
  localparam int unsigned FP16_BIAS       = 15;
  localparam logic [15:0] FP16_MAX_FINITE = 16'h7BFF;
  localparam logic [15:0] FP16_INF        = 16'h7C00;

endpackage

// File: rtl/kacc_fp16_normalizer_if.sv
// Tile handshake bundle between the GEMM stage, the normalizer and its consumer.
//   acc_in    : 4x4 two's-complement Kulisch accumulators
//   in_valid  : acc_in valid          in_ready  : normalizer can take a tile
//   fp_out    : 4x4 binary16 results  out_valid : fp_out valid
//   out_ready : consumer accepts      ovf_flag  : some element of fp_out overflowed
// master = tile producer/consumer side, slave = normalizer side.
interface kacc_fp16_normalizer_if
  import kacc_pkg::*;
#(
  parameter int unsigned AWIDTH = KACC_AWIDTH,
  parameter int unsigned DWIDTH = 16
) ();

  logic [0:3][0:3][AWIDTH-1:0] acc_in;
  logic                        in_valid;
  logic                        in_ready;
  logic [0:3][0:3][DWIDTH-1:0] fp_out;
  logic                        out_valid;
  logic                        out_ready;
  logic                        ovf_flag;

  modport master (
    output acc_in, in_valid, out_ready,
    input  in_ready, fp_out, out_valid, ovf_flag
  );

  modport slave (
    input  acc_in, in_valid, out_ready,
    output in_ready, fp_out, out_valid, ovf_flag
  );

endinterface

// File: rtl/kacc_fp16_normalizer_to_fp16.sv
// kacc_to_fp16: combinational conversion of one Kulisch accumulator element
// to IEEE-754 binary16 with round-to-nearest-even and gradual underflow.
//   i_acc : two's-complement accumulator, bit 0 weight 2^-FRAC_BITS
//   o_fp  : binary16 result
//   o_ovf : result exceeded the binary16 finite range
// Build option KACC_SAT_EN: overflow saturates to +/-max finite instead of +/-Inf.
module kacc_to_fp16
  import kacc_pkg::*;
#(
  parameter int unsigned AWIDTH    = KACC_AWIDTH,
  parameter int unsigned FRAC_BITS = KACC_FRAC_BITS
) (
  input  logic [AWIDTH-1:0] i_acc,
  output logic [15:0]       o_fp,
  output logic              o_ovf
);

  // Accumulator bit whose weight is 2^-14, the binary16 minimum normal.
  localparam int unsigned SUB_POS = FRAC_BITS - 14;

`ifdef KACC_SAT_EN
  localparam logic [14:0] OVF_MAG = FP16_MAX_FINITE[14:0];
`else
  localparam logic [14:0] OVF_MAG = FP16_INF[14:0];
`endif

  logic              w_sign;
  logic              w_nonneg;
  logic              w_zero;
  logic              w_guard;
  logic              w_sticky;
  logic              w_rup;
  logic [AWIDTH-1:0] w_mag;
  logic [AWIDTH-1:0] w_norm;
  int unsigned       w_msb;
  int unsigned       w_pos;
  int unsigned       w_efield;
  logic [31:0]       w_val;

  always_comb begin
    w_sign   = i_acc[AWIDTH-1];
    w_nonneg = w_sign & ~(|i_acc[AWIDTH-2:0]);
    w_zero   = ~(|i_acc);
    w_mag    = w_sign ? (~i_acc + AWIDTH'(1)) : i_acc;

    w_msb = 0;
    for (int unsigned i = 0; i < AWIDTH; i++) begin
      if (w_mag[i]) w_msb = i;
    end

    // Below the normal range the significand window is pinned at the
    // min-normal position, which performs the denormalizing shift; the
    // hidden bit then reads 0 and the exponent field becomes 0.
    w_pos    = (w_msb > SUB_POS) ? w_msb : SUB_POS;
    w_norm   = w_mag << (AWIDTH - 1 - w_pos);
    w_efield = w_norm[AWIDTH-1] ? (w_pos - SUB_POS + 1) : 0;

    w_guard  = w_norm[AWIDTH-12];
    w_sticky = |w_norm[AWIDTH-13:0];
    w_rup    = w_guard & (w_sticky | w_norm[AWIDTH-11]);

    // Rounding increment ripples from the fraction into the exponent field,
    // covering both the normal carry-out and subnormal -> min normal.
    w_val = (32'(w_efield) << 10) + 32'(w_norm[AWIDTH-2 -: 10]) + 32'(w_rup);

    o_ovf = w_nonneg | (|w_val[31:15]) | (&w_val[14:10]);

    if (o_ovf)       o_fp = {w_sign, OVF_MAG};
    else if (w_zero) o_fp = 16'h0000;
    else             o_fp = {w_sign, w_val[14:0]};
  end

endmodule

// File: rtl/kacc_fp16_normalizer.sv
// kacc_fp16_normalizer: accepts a 4x4 tile of Kulisch accumulators, converts
// it to binary16 one element per cycle (row-major) and presents the tile with
// an overflow summary flag until the consumer accepts it.
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active high
//   bus   : kacc_fp16_normalizer_if.slave (tile in / tile out handshake)
// Build option KACC_SAT_EN (in kacc_to_fp16): saturate instead of Inf on overflow.
module kacc_fp16_normalizer
  import kacc_pkg::*;
#(
  parameter int unsigned AWIDTH    = KACC_AWIDTH,
  parameter int unsigned FRAC_BITS = KACC_FRAC_BITS,
  parameter int unsigned DWIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  kacc_fp16_normalizer_if.slave   bus
);

  kacc_state_t                 r_state;
  logic [4:0]                  r_idx;
  logic                        r_in_ready;
  logic                        r_out_valid;
  logic                        r_ovf;
  logic [0:3][0:3][DWIDTH-1:0] r_fp;
  logic [AWIDTH-1:0]           r_buf [0:15];

  logic [15:0]                 w_fp;
  logic                        w_ovf;

  kacc_to_fp16 #(
    .AWIDTH    (AWIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_cvt (
    .i_acc (r_buf[r_idx[3:0]]),
    .o_fp  (w_fp),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && bus.in_valid) begin
      for (int unsigned i = 0; i < 16; i++) begin
        r_buf[i] <= bus.acc_in[i / 4][i % 4];
      end
    end
  end

  // Index runs 0..16: slots 0..15 write results, slot 16 is the extra cycle
  // that lands out_valid on the 17th edge after acceptance.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_fp        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_state    <= ST_CONV;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_ovf      <= 1'b0;
          end
        end
        ST_CONV: begin
          if (r_idx == 5'd16) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_fp[r_idx[3:2]][r_idx[1:0]] <= DWIDTH'(w_fp);
            r_ovf <= r_ovf | w_ovf;
            r_idx <= r_idx + 5'd1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.ovf_flag  = r_ovf;
  assign bus.fp_out    = r_fp;

endmodule

// File: tb/tb_kacc_fp16_normalizer.sv
module tb_kacc_fp16_normalizer;
  import kacc_pkg::*;

  localparam int unsigned AW = 91;
  typedef logic [AW-1:0] acc_t;
  typedef logic [0:3][0:3][AW-1:0] tile_t;
  typedef struct {
    logic [0:15][15:0] fp;
    logic              ovf;
  } exp_t;
  typedef struct {
    acc_t        acc;
    logic [15:0] fp;
    logic        ovf;
  } vec_t;

`ifdef KACC_SAT_EN
  localparam logic [15:0] OVP = 16'h7BFF;
  localparam logic [15:0] OVN = 16'hFBFF;
`else
  localparam logic [15:0] OVP = 16'h7C00;
  localparam logic [15:0] OVN = 16'hFC00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  kacc_fp16_normalizer_if #(.AWIDTH(AW), .DWIDTH(16)) bus ();

  kacc_fp16_normalizer #(.AWIDTH(AW), .FRAC_BITS(48), .DWIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sbq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_tile(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout actual=expired required=event", name);
  endtask

  // Scoreboard: compare every tile the consumer accepts.
  always @(negedge clk) begin
    if (!rst_n && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        timeout_fail("unexpected_tile");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        for (int i = 0; i < 16; i++)
          chk($sformatf("fp[%0d]", i), 32'(bus.fp_out[i / 4][i % 4]), 32'(e.fp[i]));
        chk("ovf_flag", 32'(bus.ovf_flag), 32'(e.ovf));
      end
    end
  end

  // Called at posedge+#1; returns at acceptance edge +#1.
  task automatic send(input tile_t t, input exp_t e, input bit push);
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) timeout_fail("in_ready");
    bus.acc_in   = t;
    bus.in_valid = 1'b1;
    if (push) sbq.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.out_valid && n < 100);
    if (!bus.out_valid) timeout_fail("out_valid");
  endtask

  vec_t  vt [19];
  tile_t tile_a, tile_b, tile_t0;
  exp_t  exp_a, exp_b, exp_t0;
  int    lat;

  initial begin
    vt[0]  = '{acc_t'(1) << 48, 16'h3C00, 1'b0};
    vt[1]  = '{-(acc_t'(3) << 47), 16'hBE00, 1'b0};
    vt[2]  = '{acc_t'(3) << 23, 16'h0002, 1'b0};
    vt[3]  = '{acc_t'(1) << 23, 16'h0000, 1'b0};
    vt[4]  = '{acc_t'(1) << 64, OVP, 1'b1};
    vt[5]  = '{-(acc_t'(1) << 90), OVN, 1'b1};
    vt[6]  = '{acc_t'(0), 16'h0000, 1'b0};
    vt[7]  = '{-(acc_t'(1) << 48), 16'hBC00, 1'b0};
    vt[8]  = '{acc_t'(1) << 63, 16'h7800, 1'b0};
    vt[9]  = '{acc_t'(2047) << 53, 16'h7BFF, 1'b0};
    vt[10] = '{acc_t'(4095) << 52, OVP, 1'b1};
    vt[11] = '{acc_t'(1) << 24, 16'h0001, 1'b0};
    vt[12] = '{acc_t'(2047) << 23, 16'h0400, 1'b0};
    vt[13] = '{acc_t'(1) << 34, 16'h0400, 1'b0};
    vt[14] = '{(acc_t'(1) << 48) + (acc_t'(1) << 37), 16'h3C00, 1'b0};
    vt[15] = '{(acc_t'(1) << 48) + (acc_t'(1) << 37) + (acc_t'(1) << 8), 16'h3C01, 1'b0};
    vt[16] = '{(acc_t'(1) << 48) + (acc_t'(1) << 38) + (acc_t'(1) << 37), 16'h3C02, 1'b0};
    vt[17] = '{(acc_t'(1) << 23) + acc_t'(1), 16'h0001, 1'b0};
    vt[18] = '{acc_t'(1) << 47, 16'h3800, 1'b0};

    bus.acc_in    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ovf", 32'(bus.ovf_flag), 32'd0);
    chk_tile("rst_fp_out", bus.fp_out, '0);
    rst_n = 1'b0;
    @(posedge clk); #1;

    // Single 1.0 at [0][0]: latency and values.
    tile_a = '0;
    tile_a[0][0] = acc_t'(1) << 48;
    exp_a.fp = '0;
    exp_a.fp[0] = 16'h3C00;
    exp_a.ovf = 1'b0;
    send(tile_a, exp_a, 1'b1);
    wait_out_valid(lat);
    chk("latency_a", 32'(lat), 32'd17);
    @(posedge clk); #1;

    // Placement tile held in DONE for 5 cycles with in_valid asserted.
    tile_b = '0;
    tile_b[3][3] = -(acc_t'(3) << 47);
    tile_b[1][2] = acc_t'(3) << 23;
    tile_b[0][1] = acc_t'(1) << 23;
    exp_b.fp = '0;
    exp_b.fp[15] = 16'hBE00;
    exp_b.fp[6]  = 16'h0002;
    exp_b.fp[1]  = 16'h0000;
    exp_b.ovf = 1'b0;
    bus.out_ready = 1'b0;
    send(tile_b, exp_b, 1'b1);
    wait_out_valid(lat);
    chk("latency_b", 32'(lat), 32'd17);
    for (int k = 0; k < 5; k++) begin
      bus.acc_in   = tile_a;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("hold_valid[%0d]", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("hold_ready[%0d]", k), 32'(bus.in_ready), 32'd0);
      chk_tile($sformatf("hold_fp[%0d]", k), bus.fp_out, exp_b.fp);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    chk("no_ghost_tile", 32'(bus.in_ready), 32'd1);

    // Table tiles back to back: overflow tile then clean tile.
    for (int t = 0; t < 2; t++) begin
      tile_t0 = '0;
      exp_t0.fp = '0;
      exp_t0.ovf = 1'b0;
      for (int e = 0; e < 16; e++) begin
        if (t * 16 + e < 19) begin
          tile_t0[e / 4][e % 4] = vt[t * 16 + e].acc;
          exp_t0.fp[e] = vt[t * 16 + e].fp;
          exp_t0.ovf = exp_t0.ovf | vt[t * 16 + e].ovf;
        end
      end
      send(tile_t0, exp_t0, 1'b1);
    end
    wait_out_valid(lat);
    @(posedge clk); #1;

    // Reset pulse mid-conversion at index 7.
    send(tile_a, exp_a, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_ovf", 32'(bus.ovf_flag), 32'd0);
    chk_tile("midrst_fp_out", bus.fp_out, '0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    send(tile_a, exp_a, 1'b1);
    wait_out_valid(lat);
    chk("latency_after_rst", 32'(lat), 32'd17);

    begin
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 200) begin
        @(posedge clk); #1; n++;
      end
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kacc_fp16_normalizer.md
KACC_FP16_NORMALIZER -- requirements
Module: kacc_fp16_normalizer

Interface
REQ-001 Parameter AWIDTH, default 91, width of one Kulisch accumulator element.
REQ-002 Parameter FRAC_BITS, default 48, accumulator fractional bits (bit 0 weight 2^-48).
REQ-003 Parameter DWIDTH, default 16, output FP16 element width.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-high.
REQ-006 acc_in  input  [0:3][0:3][AWIDTH-1:0]  4x4 two's-complement Kulisch results from the tensor-core GEMM stage.
REQ-007 in_valid  input  1  acc_in valid.
REQ-008 in_ready  output  1  block can accept a tile.
REQ-009 fp_out  output  [0:3][0:3][DWIDTH-1:0]  4x4 IEEE-754 binary16 results.
REQ-010 out_valid  output  1  fp_out valid.
REQ-011 out_ready  input  1  consumer accepts fp_out.
REQ-012 ovf_flag  output  1  at least one element of the current fp_out tile overflowed binary16.

Function
REQ-013 FSM states IDLE, CONV, DONE; encoding from shared package.
REQ-014 in_ready = 1 only in IDLE; tile accepted on an edge with in_valid & in_ready, captured into an internal 16x AWIDTH buffer; FSM -> CONV, element index = 0.
REQ-015 CONV converts one element per cycle in row-major order (index 0 = [0][0], 15 = [3][3]) and writes the result into the fp_out register at that index.
REQ-016 After index 15 is written, FSM -> DONE; out_valid rises at the 17th rising edge after the accepting edge.
REQ-017 DONE holds out_valid = 1 with fp_out and ovf_flag stable until an edge with out_ready = 1; then FSM -> IDLE, out_valid = 0.
REQ-018 in_valid is ignored outside IDLE; no tile is dropped or overwritten; same-cycle acceptance of a new tile while leaving DONE is not permitted (one idle cycle minimum).
REQ-019 Conversion: sign = acc MSB; magnitude = |acc|; exponent = (MSB position of magnitude) - FRAC_BITS + 15.
REQ-020 Rounding: round-to-nearest-even on the 11-bit significand (10 stored + hidden); guard and sticky cover all lower bits.
REQ-021 Rounding carry-out increments the exponent; a result reaching biased exponent 31 is overflow.
REQ-022 Biased exponent <= 0 produces a binary16 subnormal via denormalizing shift before rounding; rounding up from the largest subnormal produces 0x0400 (min normal).
REQ-023 Zero accumulator -> 0x0000 (never -0).
REQ-024 Accumulator -2^(AWIDTH-1) (non-negatable) -> overflow, negative.
REQ-025 Overflow sets ovf_flag for the tile; ovf_flag clears on capture of the next tile.

Reset
REQ-026 Reset (asserted at any time, including mid-CONV or in DONE) forces IDLE, index 0, in_ready = 1 after release, out_valid = 0, ovf_flag = 0, fp_out = all zeros; a partially converted tile is discarded.

Configuration
REQ-027 Macro KACC_SAT_EN defined: overflow yields ±max finite (0x7BFF / 0xFBFF).
REQ-028 KACC_SAT_EN undefined: overflow yields ±Inf (0x7C00 / 0xFC00); ovf_flag behaves identically in both builds.

Structure
REQ-029 Shared package kacc_pkg holds the FSM state typedef, AWIDTH/FRAC_BITS defaults, FP16 bias (15), FP16 max-finite and Inf constants.
REQ-030 A single combinational sub-module kacc_to_fp16 converts one element (REQ-019..024, 027/028); the top holds FSM, index counter, buffers and handshake.

Verification
REQ-031 Element = 2^48 (1.0), others 0 -> out_valid at edge 17 after accept; fp_out[0][0] = 0x3C00, rest 0x0000, ovf_flag = 0.
REQ-032 Element [3][3] = -(3*2^47) (-1.5) -> 0xBE00; element [1][2] = 3*2^23 (1.5*2^-24) -> 0x0002; element = 2^23 (tie, 2^-25) -> 0x0000.
REQ-033 Element = 2^64 (65536) -> 0x7C00 without KACC_SAT_EN, 0x7BFF with it; ovf_flag = 1; next tile with no overflow clears ovf_flag.
REQ-034 out_ready held low 5 cycles in DONE -> out_valid, fp_out stable, in_ready = 0, in_valid ignored; release -> IDLE next edge.
REQ-035 rst_n pulsed at index 7 of CONV -> out_valid = 0, fp_out = 0, next tile converts correctly with full 17-cycle latency.
REQ-036 Element = -2^90 -> 0xFC00 (0xFBFF with KACC_SAT_EN), ovf_flag = 1.
